// File: rtl/pp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_pkg
//  Description : Shared types and default sizes for the ping-pong controller.
//  Revision    : 1.0  initial release
// ============================================================================
package pp_pkg;

    localparam int PP_DATA_WIDTH = 32;
    localparam int PP_DEPTH      = 16;
    localparam int PP_ADDRW      = 4;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // One-hot bank enable from a bank select bit (bit0 = bank0).
    function automatic logic [1:0] bank_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage : pp_pkg
`default_nettype wire

// File: rtl/pp_bank_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pp_bank_fsm
//  Description : Occupancy state machine for one RAM bank of the ping-pong pair.
//  Revision    : 1.0  initial release
// ============================================================================
module pp_bank_fsm
    import pp_pkg::*;
(
    input  logic clk,
    input  logic aresetn,
    input  logic i_wr_acc,
    input  logic i_wr_last,
    input  logic i_rd_acc,
    input  logic i_rd_last,
    output logic o_writable,
    output logic o_readable
);

    bank_state_e r_state;
    bank_state_e w_next;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= BANK_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            BANK_EMPTY: begin
                if (i_wr_acc) begin
                    w_next = i_wr_last ? BANK_FULL : BANK_FILLING;
                end
            end
            BANK_FILLING: begin
                if (i_wr_acc && i_wr_last) begin
                    w_next = BANK_FULL;
                end
            end
            BANK_FULL: begin
                if (i_rd_acc) begin
                    w_next = i_rd_last ? BANK_EMPTY : BANK_DRAINING;
                end
            end
            BANK_DRAINING: begin
                if (i_rd_acc && i_rd_last) begin
                    w_next = BANK_EMPTY;
                end
            end
            default: w_next = BANK_EMPTY;
        endcase
    end

    // Writable and readable are mutually exclusive, so a bank is never
    // written and read in the same cycle.
    always_comb begin
        o_writable = (r_state == BANK_EMPTY) || (r_state == BANK_FILLING);
        o_readable = (r_state == BANK_FULL)  || (r_state == BANK_DRAINING);
    end

endmodule : pp_bank_fsm
`default_nettype wire

// File: rtl/ping_pong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ping_pong_ctrl
//  Description : Two-bank ping-pong buffer controller between an input and an
//                output stream, driving two external single-cycle-read RAMs.
//  Revision    : 1.0  initial release
// ============================================================================
module ping_pong_ctrl
    import pp_pkg::*;
#(
    parameter int DATA_WIDTH = PP_DATA_WIDTH,
    parameter int DEPTH      = PP_DEPTH,
    parameter int ADDRW      = PP_ADDRW
) (
    input  logic                  clk,
    input  logic                  aresetn,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic [1:0]            ram_ena,
    output logic [1:0]            ram_enb,
    output logic                  ram_wea,
    output logic [ADDRW-1:0]      ram_addra,
    output logic [ADDRW-1:0]      ram_addrb,
    output logic [DATA_WIDTH-1:0] ram_dia,
    input  logic [DATA_WIDTH-1:0] ram0_dob,
    input  logic [DATA_WIDTH-1:0] ram1_dob,

    output logic                  err_frame,
    output logic [15:0]           frame_cnt
);

    localparam logic [ADDRW-1:0] c_LAST_ADDR = ADDRW'(DEPTH - 1);

    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [ADDRW-1:0] r_wr_addr;
    logic [ADDRW-1:0] r_rd_addr;
    logic             r_err_frame;
    logic [15:0]      r_frame_cnt;

    logic [1:0]       w_writable;
    logic [1:0]       w_readable;
    logic [1:0]       w_bank_wr_acc;
    logic [1:0]       w_bank_rd_acc;
    logic             w_wr_ready;
    logic             w_wr_hs;
    logic             w_wr_last;
    logic             w_rd_valid;
    logic             w_rd_hs;
    logic             w_rd_last;

    assign w_wr_ready = w_writable[r_wr_sel];
    assign w_wr_hs    = s_axis_tvalid && w_wr_ready;
    assign w_wr_last  = (r_wr_addr == c_LAST_ADDR);

    assign w_rd_valid = w_readable[r_rd_sel];
    assign w_rd_hs    = w_rd_valid && m_axis_tready;
    assign w_rd_last  = (r_rd_addr == c_LAST_ADDR);

    assign w_bank_wr_acc = w_wr_hs ? bank_onehot(r_wr_sel) : 2'b00;
    assign w_bank_rd_acc = w_rd_hs ? bank_onehot(r_rd_sel) : 2'b00;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            pp_bank_fsm u_fsm (
                .clk        (clk),
                .aresetn    (aresetn),
                .i_wr_acc   (w_bank_wr_acc[gi]),
                .i_wr_last  (w_wr_last),
                .i_rd_acc   (w_bank_rd_acc[gi]),
                .i_rd_last  (w_rd_last),
                .o_writable (w_writable[gi]),
                .o_readable (w_readable[gi])
            );
        end
    endgenerate

    // Bank closure depends only on the word count, never on tlast.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_sel  <= 1'b0;
            r_wr_addr <= '0;
        end else if (w_wr_hs) begin
            if (w_wr_last) begin
                r_wr_sel  <= ~r_wr_sel;
                r_wr_addr <= '0;
            end else begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_sel    <= 1'b0;
            r_rd_addr   <= '0;
            r_frame_cnt <= '0;
        end else if (w_rd_hs) begin
            if (w_rd_last) begin
                r_rd_sel    <= ~r_rd_sel;
                r_rd_addr   <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_frame <= 1'b0;
        end else if (w_wr_hs && (s_axis_tlast != w_wr_last)) begin
            r_err_frame <= 1'b1;
        end
    end

    always_comb begin
        s_axis_tready = w_wr_ready;
        ram_ena       = w_bank_wr_acc;
        ram_wea       = w_wr_hs;
        ram_addra     = r_wr_addr;
        ram_dia       = s_axis_tdata;

        m_axis_tvalid = w_rd_valid;
        m_axis_tlast  = w_rd_valid && w_rd_last;
        m_axis_tdata  = r_rd_sel ? ram1_dob : ram0_dob;
        ram_enb       = w_rd_valid ? bank_onehot(r_rd_sel) : 2'b00;
        ram_addrb     = r_rd_addr;

        err_frame     = r_err_frame;
        frame_cnt     = r_frame_cnt;
    end

endmodule : ping_pong_ctrl
`default_nettype wire

// File: tb/tb_ping_pong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ping_pong_ctrl
//  Description : Self-checking bench for ping_pong_ctrl with a frame-queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ping_pong_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [1:0]    ram_ena;
    logic [1:0]    ram_enb;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dia;
    logic [DW-1:0] ram0_dob;
    logic [DW-1:0] ram1_dob;
    logic          err_frame;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    ping_pong_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRW(AW)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .ram_ena       (ram_ena),
        .ram_enb       (ram_enb),
        .ram_wea       (ram_wea),
        .ram_addra     (ram_addra),
        .ram_addrb     (ram_addrb),
        .ram_dia       (ram_dia),
        .ram0_dob      (ram0_dob),
        .ram1_dob      (ram1_dob),
        .err_frame     (err_frame),
        .frame_cnt     (frame_cnt)
    );

    // External RAMs: synchronous write, combinational read.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    always @(posedge clk) begin
        if (ram_wea && ram_ena[0]) mem0[ram_addra] <= ram_dia;
        if (ram_wea && ram_ena[1]) mem1[ram_addra] <= ram_dia;
    end
    assign ram0_dob = mem0[ram_addrb];
    assign ram1_dob = mem1[ram_addrb];

    // Reference model: words of the frame being collected, words of complete
    // frames awaiting output, and frame counters on each side.
    logic [DW-1:0] cur_q [$];
    logic [DW-1:0] done_q[$];
    int unsigned   frames_wr;
    int unsigned   frames_rd;
    bit            err_m;
    logic [DW-1:0] out_log[$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int unsigned idx);
        return (idx % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_clear();
        cur_q.delete();
        done_q.delete();
        out_log.delete();
        frames_wr = 0;
        frames_rd = 0;
        err_m     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_err", err_frame, 1'b0);
        chk("rst_ena", ram_ena, 2'b00);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        model_clear();
        #1;
        chk("rst_tready", s_axis_tready, 1'b1);
        chk("rst_tvalid_rel", m_axis_tvalid, 1'b0);
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model by the handshakes the model predicts.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l,
                         input bit rdy, output bit acc);
        int  occ;
        int  remain;
        bit  e_ready, e_valid, e_last, whs, rhs;
        @(negedge clk);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = rdy;
        #1;
        occ     = (done_q.size() + DEPTH - 1) / DEPTH;
        e_ready = (occ < 2);
        e_valid = (occ >= 1);
        remain  = e_valid ? ((done_q.size() - 1) % DEPTH) + 1 : 0;
        e_last  = e_valid && (remain == 1);
        whs     = v && e_ready;
        rhs     = e_valid && rdy;

        chk("s_tready", s_axis_tready, e_ready);
        chk("m_tvalid", m_axis_tvalid, e_valid);
        chk("m_tlast", m_axis_tlast, e_last);
        chk("ram_enb", ram_enb, e_valid ? onehot(frames_rd) : 2'b00);
        if (e_valid) begin
            chk("m_tdata", m_axis_tdata, done_q[0]);
            chk("ram_addrb", ram_addrb, DEPTH - remain);
        end
        chk("ram_wea", ram_wea, whs);
        chk("ram_ena", ram_ena, whs ? onehot(frames_wr) : 2'b00);
        if (whs) begin
            chk("ram_addra", ram_addra, cur_q.size());
            chk("ram_dia", ram_dia, d);
        end
        chk("frame_cnt", frame_cnt, frames_rd[15:0]);
        chk("err_frame", err_frame, err_m);

        acc = v && s_axis_tready;
        if (m_axis_tvalid && rdy) out_log.push_back(m_axis_tdata);

        @(posedge clk);
        if (rhs) begin
            void'(done_q.pop_front());
            if (done_q.size() % DEPTH == 0) frames_rd++;
        end
        if (whs) begin
            if (l != (cur_q.size() == DEPTH - 1)) err_m = 1'b1;
            cur_q.push_back(d);
            if (cur_q.size() == DEPTH) begin
                foreach (cur_q[k]) done_q.push_back(cur_q[k]);
                cur_q.delete();
                frames_wr++;
            end
        end
    endtask

    initial begin
        bit acc;
        int n;
        int acc_sum;
        logic [DW-1:0] dat;
        bit lst;

        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        model_clear();

        // Single frame 0..15 passes through in order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), i == DEPTH - 1, 1'b1, acc);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("f1_count", out_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("f1_data", out_log[i], i);
        chk("f1_frame_cnt", frame_cnt, 16'd1);
        chk("f1_err", err_frame, 1'b0);

        // Reader stalled: writer fills both banks then stalls; nothing lost.
        do_reset();
        n = 0;
        for (int c = 0; c < 60; c++) begin
            cycle(n < 48, DW'(n), (n % DEPTH) == DEPTH - 1, 1'b0, acc);
            if (acc) n++;
        end
        chk("stall_accepted", n, 32);
        #1;
        chk("stall_tready", s_axis_tready, 1'b0);
        for (int c = 0; c < 400 && out_log.size() < 48; c++) begin
            cycle(n < 48, DW'(n), (n % DEPTH) == DEPTH - 1, 1'b1, acc);
            if (acc) n++;
        end
        chk("stall_out_cnt", out_log.size(), 48);
        for (int i = 0; i < 40; i++) chk("stall_order", out_log[i], i);

        // Continuous streaming on both sides: no write bubbles.
        do_reset();
        acc_sum = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, DW'(i + 100), (i % DEPTH) == DEPTH - 1, 1'b1, acc);
            if (acc) acc_sum++;
        end
        chk("stream_no_bubble", acc_sum, 64);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("stream_frame_cnt", frame_cnt, 16'd4);
        chk("stream_out_cnt", out_log.size(), 64);
        chk("stream_last_word", out_log[63], 163);

        // Early tlast flags an error but the bank still closes on word 15.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(i + 500), i == 7, 1'b0, acc);
            if (i == 8) chk("early_err_set", err_frame, 1'b1);
        end
        #1;
        chk("early_bank_closed", m_axis_tvalid, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), i == DEPTH - 1, 1'b1, acc);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("early_err_sticky", err_frame, 1'b1);
        chk("early_frame_cnt", frame_cnt, 16'd2);

        // Reset in the middle of a frame discards the partial frame.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, DW'(i + 900), 1'b0, 1'b1, acc);
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), i == DEPTH - 1, 1'b1, acc);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
        chk("mid_rst_frame_cnt", frame_cnt, 16'd1);
        chk("mid_rst_out_cnt", out_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("mid_rst_data", out_log[i], i);

        // Random traffic with occasional tlast errors, checked against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            dat = DW'($urandom);
            lst = (cur_q.size() == DEPTH - 1) ^ ($urandom_range(0, 63) == 0);
            cycle($urandom_range(0, 3) != 0, dat, lst,
                  (c % 400 < 100) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0),
                  acc);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ping_pong_ctrl
`default_nettype wire
